// File: rtl/chip_spreader_if.sv
// chip_spreader_if: symbol handshake, chip-rate strobe and serial chip stream of chip_spreader.
interface chip_spreader_if;
   logic [3:0] inSymbol;
   logic       inSymValid;
   logic       outSymReady;
   logic       inChipEn;
   logic       outChip;
   logic [4:0] outChipIdx;
   logic       outChipValid;
   logic       outBusy;
   logic       outDone;
   modport master (
      output inSymbol, inSymValid, inChipEn,
      input  outSymReady, outChip, outChipIdx, outChipValid, outBusy, outDone
   );
   modport slave (
      input  inSymbol, inSymValid, inChipEn,
      output outSymReady, outChip, outChipIdx, outChipValid, outBusy, outDone
   );
endinterface

// File: rtl/chip_spreader.sv
// chip_spreader: maps 4-bit symbols to 32-chip 802.15.4 O-QPSK PN sequences, one chip per strobe.
module chip_spreader #(
   parameter logic IDLE_CHIP = 1'b0
) (
   input logic           inClk,
   input logic           inRst,
   chip_spreader_if.slave bus
);
   localparam logic [31:0] SEQ0 = 32'b1101_1001_1100_0011_0101_0010_0010_1110;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
   state_t     r_state, w_state;
   logic [3:0] r_hold, w_hold, r_sym, w_sym;
   logic       r_hold_full, w_hold_full;
   logic [5:0] r_idx, w_idx;
   logic       r_chip, w_chip, r_valid, w_valid, r_done, w_done;
   logic [4:0] r_chip_idx, w_chip_idx;
   logic [4:0] w_pos, w_rom_idx;
   logic       w_seq_bit, w_accept, w_last;
   // SEQ0 holds chip 0 in its MSB; rotation by 4k chips is an index offset, odd chips flip for k>=8
   assign w_pos     = r_idx[4:0] - {r_sym[2:0], 2'b00};
   assign w_rom_idx = ~w_pos;
   assign w_seq_bit = SEQ0[w_rom_idx] ^ (r_sym[3] & r_idx[0]);
   assign w_accept  = bus.inSymValid & ~r_hold_full;
   assign w_last    = r_idx[4:0] == 5'd31;
   always_comb begin
      w_state     = r_state;
      w_hold      = r_hold;
      w_hold_full = r_hold_full;
      w_sym       = r_sym;
      w_idx       = r_idx;
      w_chip      = r_chip;
      w_chip_idx  = r_chip_idx;
      w_valid     = r_valid;
      w_done      = 1'b0;
      if (w_accept) begin
         w_hold      = bus.inSymbol;
         w_hold_full = 1'b1;
      end
      case (r_state)
         IDLE: if (r_hold_full) begin
            w_sym       = r_hold;
            w_hold_full = 1'b0;
            w_idx       = 6'd0;
            w_state     = RUN;
         end
         RUN: if (r_idx[5] && r_hold_full) begin
            // symbol arrived after chip 31 went out: reload without waiting for a strobe
            w_sym       = r_hold;
            w_hold_full = 1'b0;
            w_idx       = 6'd0;
         end else if (bus.inChipEn) begin
            if (!r_idx[5]) begin
               w_chip     = w_seq_bit;
               w_chip_idx = r_idx[4:0];
               w_valid    = 1'b1;
               w_idx      = r_idx + 6'd1;
               if (w_last && r_hold_full) begin
                  w_sym       = r_hold;
                  w_hold_full = 1'b0;
                  w_idx       = 6'd0;
               end
            end else begin
               w_chip  = IDLE_CHIP;
               w_valid = 1'b0;
               w_done  = 1'b1;
               w_state = IDLE;
            end
         end
         default: w_state = IDLE;
      endcase
   end
   always_ff @(posedge inClk or posedge inRst) begin
      if (inRst) begin
         r_state     <= IDLE;
         r_hold      <= 4'd0;
         r_hold_full <= 1'b0;
         r_sym       <= 4'd0;
         r_idx       <= 6'd0;
         r_chip      <= IDLE_CHIP;
         r_chip_idx  <= 5'd0;
         r_valid     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_hold      <= w_hold;
         r_hold_full <= w_hold_full;
         r_sym       <= w_sym;
         r_idx       <= w_idx;
         r_chip      <= w_chip;
         r_chip_idx  <= w_chip_idx;
         r_valid     <= w_valid;
         r_done      <= w_done;
      end
   end
   assign bus.outSymReady  = ~r_hold_full;
   assign bus.outChip      = r_chip;
   assign bus.outChipIdx   = r_chip_idx;
   assign bus.outChipValid = r_valid;
   assign bus.outBusy      = (r_state == RUN) | r_hold_full;
   assign bus.outDone      = r_done;
endmodule

// File: tb/tb_chip_spreader.sv
// tb_chip_spreader: directed stimulus with a chip scoreboard for chip_spreader.
module tb_chip_spreader;
   logic clk = 1'b0;
   logic rst = 1'b0;
   chip_spreader_if b();
   chip_spreader #(.IDLE_CHIP(1'b0)) dut (.inClk(clk), .inRst(rst), .bus(b));
   string S0 = "11011001110000110101001000101110";
   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int en_div = 1;
   int ph = 0;
   logic [5:0] q[$];
   logic en_q = 1'b0;
   logic pv = 1'b0;
   logic [4:0] pidx = 5'd0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic model(int k, int i);
      logic c;
      c = (S0[(i - 4 * (k % 8) + 32) % 32] == "1");
      return c ^ (k >= 8 && i % 2 == 1);
   endfunction
   task automatic push_str(input string s);
      for (int i = 0; i < 32; i++) q.push_back({s[i] == "1", 5'(i)});
   endtask
   task automatic push_model(input int k);
      for (int i = 0; i < 32; i++) q.push_back({model(k, i), 5'(i)});
   endtask
   task automatic send(input logic [3:0] k, output int n);
      n = 0;
      b.inSymbol = k;
      b.inSymValid = 1'b1;
      while (!b.outSymReady && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("ready_timeout", n < 500, 1);
      @(negedge clk);
      b.inSymValid = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (b.outBusy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", n < 3000, 1);
      repeat (3) @(negedge clk);
      check("sb_drained", q.size(), 0);
   endtask
   initial begin
      forever begin
         @(negedge clk);
         ph++;
         b.inChipEn = (ph % en_div == 0);
      end
   end
   always @(posedge clk) en_q = b.inChipEn;
   always @(negedge clk) begin
      if (b.outChipValid && (!pv || b.outChipIdx != pidx)) begin
         check("chip_on_strobe", en_q, 1);
         check("sb_nonempty", q.size() != 0, 1);
         if (q.size() != 0) check("chip", {b.outChip, b.outChipIdx}, q.pop_front());
      end
      pv = b.outChipValid;
      pidx = b.outChipIdx;
      if (b.outDone) begin
         done_cnt++;
         check("done_busy", b.outBusy, 0);
      end
   end
   initial begin
      int n, d0, gap;
      logic started;
      b.inSymbol = 4'd0;
      b.inSymValid = 1'b0;
      b.inChipEn = 1'b0;
      #1 rst = 1'b1;
      #2;
      check("rst_ready", b.outSymReady, 1);
      check("rst_chip", b.outChip, 0);
      check("rst_idx", b.outChipIdx, 0);
      check("rst_valid", b.outChipValid, 0);
      check("rst_busy", b.outBusy, 0);
      check("rst_done", b.outDone, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      // symbol 0 with a strobe every 4 clocks
      en_div = 4;
      d0 = done_cnt;
      push_str(S0);
      send(4'd0, n);
      wait_idle();
      check("sym0_done", done_cnt - d0, 1);
      // symbol 1 with strobe tied high, including load latency
      en_div = 1;
      d0 = done_cnt;
      push_str("11101101100111000011010100100010");
      send(4'd1, n);
      check("lat_accept_valid", b.outChipValid, 0);
      @(negedge clk);
      check("lat_load_valid", b.outChipValid, 0);
      check("lat_load_busy", b.outBusy, 1);
      @(negedge clk);
      check("lat_chip0", {b.outChipValid, b.outChip, b.outChipIdx}, 7'b1100000);
      wait_idle();
      check("sym1_done", done_cnt - d0, 1);
      // symbol 8
      en_div = 3;
      d0 = done_cnt;
      push_str("10001100100101100000011101111011");
      send(4'd8, n);
      wait_idle();
      check("sym8_done", done_cnt - d0, 1);
      // symbols 0 and 1 back-to-back, gapless
      en_div = 1;
      d0 = done_cnt;
      push_model(0);
      send(4'd0, n);
      push_model(1);
      send(4'd1, n);
      gap = 0;
      started = 1'b0;
      n = 0;
      while (!b.outDone && n < 500) begin
         if (b.outChipValid) started = 1'b1;
         else if (started) gap++;
         @(negedge clk);
         n++;
      end
      check("b2b_timeout", n < 500, 1);
      check("b2b_gap", gap, 0);
      wait_idle();
      check("b2b_done", done_cnt - d0, 1);
      // three symbols offered on consecutive cycles
      d0 = done_cnt;
      push_model(5);
      send(4'd5, n);
      push_model(10);
      send(4'd10, n);
      push_model(15);
      send(4'd15, n);
      check("third_stalled", n >= 28, 1);
      wait_idle();
      check("three_done", done_cnt - d0, 1);
      // reset at chip 10 with the holding buffer full
      d0 = done_cnt;
      push_model(2);
      send(4'd2, n);
      push_model(3);
      send(4'd3, n);
      n = 0;
      while (!(b.outChipValid && b.outChipIdx == 5'd10) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("chip10_timeout", n < 500, 1);
      check("hold_full_at_10", b.outSymReady, 0);
      #2 rst = 1'b1;
      #1;
      q.delete();
      check("mid_rst_valid", b.outChipValid, 0);
      check("mid_rst_ready", b.outSymReady, 1);
      check("mid_rst_idx", b.outChipIdx, 0);
      check("mid_rst_chip", b.outChip, 0);
      check("mid_rst_busy", b.outBusy, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      repeat (40) @(negedge clk);
      check("post_rst_valid", b.outChipValid, 0);
      check("post_rst_ready", b.outSymReady, 1);
      check("post_rst_busy", b.outBusy, 0);
      check("post_rst_done", done_cnt - d0, 0);
      // all 16 symbols in sequence
      en_div = 2;
      d0 = done_cnt;
      for (int k = 0; k < 16; k++) begin
         push_model(k);
         send(4'(k), n);
      end
      n = 0;
      while (!b.outDone && n < 1000) begin
         check("all16_busy", b.outBusy, 1);
         @(negedge clk);
         n++;
      end
      check("all16_timeout", n < 1000, 1);
      wait_idle();
      check("all16_done", done_cnt - d0, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/chip_spreader.md
Name: chip_spreader

Overview:
- Direct downstream consumer of the 4-bit nibble selector in the Zigbee TX datapath.
- Accepts 4-bit data symbols with a valid/ready handshake and maps each symbol to its 32-chip IEEE 802.15.4 (2.4 GHz O-QPSK) PN sequence.
- Emits the chips serially, one per chip-rate strobe, to the O-QPSK I/Q shaping stage.
- Has a one-deep holding buffer, so back-to-back symbols produce a gapless chip stream.

Parameters:
IDLE_CHIP, 1'b0, value driven on outChip whenever outChipValid=0

Ports:
inClk  input  1  system clock, all state updates on rising edge
inRst  input  1  asynchronous active-high reset
inSymbol  input  4  data symbol (nibble), sampled on accept
inSymValid  input  1  inSymbol valid
outSymReady  output  1  holding buffer empty; accept occurs when inSymValid && outSymReady at a clock edge
inChipEn  input  1  chip-rate strobe, single-cycle pulses (may be tied high)
outChip  output  1  current chip, registered
outChipIdx  output  5  index (0..31) of the chip on outChip
outChipValid  output  1  outChip carries a live chip
outBusy  output  1  state RUN or holding buffer full
outDone  output  1  one-cycle pulse when the stream ends with nothing pending

Behaviour:
- Reset, async, while inRst=1:
  - state IDLE, hold empty, idx=0
  - outSymReady=1, outChip=IDLE_CHIP, outChipIdx=0
  - outChipValid=0, outBusy=0, outDone=0
- Chip table, c0 first:
  - Symbol 0 = 1101 1001 1100 0011 0101 0010 0010 1110.
  - Symbol k (1..7) = symbol 0 cyclically right-rotated by 4k chips.
  - Symbol k+8 = symbol k with odd-indexed chips inverted.
  - Implement as constant ROM or combinational generation; either is acceptable.
- Handshake:
  - outSymReady = !holdFull, registered.
  - On accept: hold <= inSymbol, holdFull <= 1.
  - Accept and transfer never coincide, because ready=0 while full.
- State IDLE:
  - If holdFull: shift symbol <= hold, holdFull <= 0, idx <= 0, go RUN.
  - The first chip is emitted on the next inChipEn, never in the load cycle, even if inChipEn=1 then.
- State RUN, on each clock with inChipEn=1:
  - If a chip remains (emitted count < 32): outChip <= seq[idx], outChipIdx <= idx, outChipValid <= 1, idx <= idx+1.
  - Chip 31 edge with holdFull=1: chip 31 is emitted, the symbol reloads from hold, and idx wraps to 0. The next strobe emits chip 0 of the new symbol, so outChipValid has no gap.
  - Strobe after chip 31 with nothing loaded: outChipValid <= 0, outChip <= IDLE_CHIP, outDone <= 1 for one cycle, go IDLE.
  - If hold filled during the final chip period: treat as IDLE-with-hold. Load next cycle; a one-chip-period gap is permitted.
- Without inChipEn, all outputs hold their values.
- Latency: accept edge → (transfer edge) → first strobe after transfer drives chip 0.
- outBusy = (state==RUN) || holdFull.
- Reset mid-symbol: immediate abort, no residual chips after release, pending symbol discarded.
- Unknown/illegal state: recover to IDLE.

Test Plan:
- Symbol 0, inChipEn every 4 clocks → 32 chips 11011001110000110101001000101110, outChipIdx 0..31; 33rd strobe drops valid and pulses outDone once.
- Symbol 1, then separately symbol 8 → chips 11101101100111000011010100100010 and 10001100100101100000011101111011 respectively.
- Symbols 0 and 1 offered back-to-back, inChipEn=1 constantly → 64 contiguous valid chips, idx wraps 31→0, a single outDone after chip 63.
- Three symbols offered on consecutive cycles → third stalls with outSymReady=0 until symbol 2 transfers (at the chip-31 strobe of symbol 1); all 96 chips in order.
- inRst asserted at chip 10 with hold full → outputs at reset values within the same cycle; after release, outChipValid stays 0 with no input, outSymReady=1.
- All 16 symbols sequentially → each 32-chip block matches the rotation/inversion rule; outBusy low only after the final outDone.
